// File: rtl/pbit_sched_pkg.sv
// Shared types and constants for the p-bit sweep scheduler.
// Holds the FSM state encoding, the beta constants, the default colour-group
// mask rule and the saturating Q4.3 add used by the annealing option.
package pbit_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENABLE = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } sched_state_e;

  // beta is signed Q4.3, so 8'sh08 is I_0 = 1.0
  localparam logic signed [7:0] I0_ONE   = 8'sh08;
  localparam logic signed [7:0] BETA_MAX = 8'sh7F;
  localparam logic signed [7:0] BETA_MIN = 8'sh80;

  // Widest mask the default rule is computed for; callers slice what they need.
  localparam int PBITS_MAX = 256;

  // Default colouring: p-bit i belongs to group (i mod num_groups).
  function automatic logic [PBITS_MAX-1:0] default_mask(input int g, input int num_groups);
    logic [PBITS_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < PBITS_MAX; i++) m[i] = ((i % num_groups) == g);
    return m;
  endfunction

  // Signed 8-bit add that clamps to the Q4.3 range instead of wrapping.
  function automatic logic signed [7:0] beta_sat_add(input logic signed [7:0] a,
                                                     input logic signed [7:0] b);
    logic signed [8:0] s;
    s = {a[7], a} + {b[7], b};
    if (s[8] != s[7]) return s[8] ? BETA_MIN : BETA_MAX;
    return s[7:0];
  endfunction

endpackage

// File: rtl/pbit_group_mask_ram.sv
// Colour-group mask table: MAX_GROUPS rows of NUM_PBITS enables.
// Resets to the default colouring; one gated write port, combinational read.
module pbit_group_mask_ram
  import pbit_sched_pkg::*;
#(
  parameter  int NUM_PBITS  = 8,
  parameter  int MAX_GROUPS = 4,
  localparam int GW         = $clog2(MAX_GROUPS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic [GW-1:0]        waddr,
  input  logic [NUM_PBITS-1:0] wdata,
  input  logic [GW-1:0]        raddr,
  output logic [NUM_PBITS-1:0] rdata
);

  function automatic logic [MAX_GROUPS-1:0][NUM_PBITS-1:0] default_rows();
    logic [MAX_GROUPS-1:0][NUM_PBITS-1:0] r;
    logic [PBITS_MAX-1:0]                 m;
    for (int g = 0; g < MAX_GROUPS; g++) begin
      m    = default_mask(g, MAX_GROUPS);
      r[g] = m[NUM_PBITS-1:0];
    end
    return r;
  endfunction

  localparam logic [MAX_GROUPS-1:0][NUM_PBITS-1:0] DEF_ROWS = default_rows();

  logic [MAX_GROUPS-1:0][NUM_PBITS-1:0] mem;

  // Row storage: reverts to the default colouring on reset, single-row write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem <= DEF_ROWS;
    end else if (we) begin
      for (int g = 0; g < MAX_GROUPS; g++)
        if (waddr == GW'(g)) mem[g] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pbit_sweep_scheduler.sv
// Programmable colour-group sequencer for the p-bit array.
// Steps through mask rows 0..last_group, each for SETTLE_CYCLES cycles
// (one enable cycle, then settle), repeats for num_sweeps sweeps and pulses
// sample_valid per completed sweep and done at run end.
// Optional macro ANNEAL_SCHED_EN adds beta_start/beta_step inputs and a
// per-sweep saturating beta ramp; otherwise beta is fixed at I_0 = 1.
module pbit_sweep_scheduler
  import pbit_sched_pkg::*;
#(
  parameter  int NUM_PBITS     = 8,
  parameter  int MAX_GROUPS    = 4,
  parameter  int SETTLE_CYCLES = 4,
  parameter  int SWEEP_W       = 16,
  localparam int GW            = $clog2(MAX_GROUPS),
  localparam int CW            = $clog2(SETTLE_CYCLES)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [SWEEP_W-1:0]   num_sweeps,
  input  logic [GW-1:0]        last_group,
  input  logic                 cfg_we,
  input  logic [GW-1:0]        cfg_addr,
  input  logic [NUM_PBITS-1:0] cfg_mask,
`ifdef ANNEAL_SCHED_EN
  input  logic signed [7:0]    beta_start,
  input  logic signed [7:0]    beta_step,
`endif
  output logic [NUM_PBITS-1:0] pbit_en,
  output logic [GW-1:0]        group_idx,
  output logic                 busy,
  output logic                 sample_valid,
  output logic                 done,
  output logic [SWEEP_W-1:0]   sweep_cnt,
  output logic signed [7:0]    beta
);

  sched_state_e         state;
  logic [SWEEP_W-1:0]   num_lat;
  logic [GW-1:0]        last_lat;
  logic [CW-1:0]        settle_cnt;
  logic [NUM_PBITS-1:0] row_mask;

  logic                 start_ok;
  logic                 settle_end;
  logic                 sweep_end;
  logic [SWEEP_W-1:0]   sweep_nxt;

  // Config writes are only honoured while no run is active.
  pbit_group_mask_ram #(
    .NUM_PBITS (NUM_PBITS),
    .MAX_GROUPS(MAX_GROUPS)
  ) u_mask_ram (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (cfg_we && !busy),
    .waddr  (cfg_addr),
    .wdata  (cfg_mask),
    .raddr  (group_idx),
    .rdata  (row_mask)
  );

  // Run-control decodes shared by the FSM and the beta ramp.
  always_comb begin
    start_ok   = (state == IDLE) && start && !stop;
    settle_end = (state == SETTLE) && !stop && (settle_cnt == CW'(SETTLE_CYCLES - 2));
    sweep_end  = settle_end && (group_idx >= last_lat);
    sweep_nxt  = sweep_cnt + SWEEP_W'(1);
  end

  // Enables are live only in the single ENABLE cycle of each group dwell.
  assign pbit_en = (state == ENABLE) ? row_mask : '0;

  // Sweep FSM: group stepping, sweep counting, stop/done handling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      group_idx    <= '0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      sweep_cnt    <= '0;
      num_lat      <= '0;
      last_lat     <= '0;
      settle_cnt   <= '0;
    end else begin
      sample_valid <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            num_lat   <= num_sweeps;
            last_lat  <= last_group;
            sweep_cnt <= '0;
            group_idx <= '0;
            if (num_sweeps == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ENABLE;
              busy  <= 1'b1;
            end
          end
        end
        ENABLE: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (settle_end) begin
            if (!sweep_end) begin
              group_idx <= group_idx + GW'(1);
              state     <= ENABLE;
            end else begin
              sweep_cnt    <= sweep_nxt;
              sample_valid <= 1'b1;
              if (sweep_nxt == num_lat) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                group_idx <= '0;
                state     <= ENABLE;
              end
            end
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ANNEAL_SCHED_EN
  // Beta ramp: load at start, step once per completed sweep, hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       beta <= I0_ONE;
    else if (start_ok)  beta <= beta_start;
    else if (sweep_end) beta <= beta_sat_add(beta, beta_step);
  end
`else
  assign beta = I0_ONE;
`endif

endmodule
